// File: rtl/nios_ram_tester_pkg.sv
// Shared types and helpers for the Avalon-MM RAM tester: FSM states, the
// address-derived test pattern and the constant byte-enable.
package nios_ram_tester_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      FIN
   } state_t;

   localparam logic [3:0] BE_ALL = 4'hF;

   // P(a) = seed ^ (a placed in the top addr_w bits) ^ zero-extended a
   function automatic logic [31:0] ram_pattern(input logic [31:0] seed,
                                               input logic [15:0] addr,
                                               input int unsigned addr_w);
      logic [31:0] a32;
      a32 = {16'h0000, addr};
      return seed ^ (a32 << (32 - addr_w)) ^ a32;
   endfunction

endpackage

// File: rtl/nios_ram_tester_rdpipe.sv
// Expected-address pipeline for reads in flight: one stage per cycle of slave
// read latency, shifting every cycle, with a flush that discards everything.
module nios_ram_tester_rdpipe #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   output logic              tail_valid,
   output logic [ADDR_W-1:0] tail_addr,
   output logic              inner_valid
);

   logic [DEPTH-1:0]  vld_q;
   logic [DEPTH-1:0]  vld_d;
   logic [ADDR_W-1:0] adr_q [DEPTH];
   logic [ADDR_W-1:0] adr_d [DEPTH];

   always_comb begin
      vld_d[0] = push & ~flush;
      adr_d[0] = push_addr;
      for (int k = 1; k < DEPTH; k++) begin
         vld_d[k] = vld_q[k-1] & ~flush;
         adr_d[k] = adr_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            adr_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         adr_q <= adr_d;
      end
   end

   assign tail_valid = vld_q[DEPTH-1];
   assign tail_addr  = adr_q[DEPTH-1];

   // inner_valid: something will still be in flight after the next shift
   generate
      if (DEPTH > 1) begin : g_inner
         assign inner_valid = |vld_q[DEPTH-2:0];
      end else begin : g_single
         assign inner_valid = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/nios_ram_tester.sv
// Avalon-MM BIST master: writes P(a) over a wrapping word range, streams it back
// and compares. Define NIOS_RAM_TESTER_INV_PASS_EN for a second pass using ~P(a).
module nios_ram_tester
   import nios_ram_tester_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+1:0] err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data,
   output logic [ADDR_W-1:0] m_address,
   output logic [3:0]        m_byteenable,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_clken,
   input  logic [DATA_W-1:0] m_readdata
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [ADDR_W+1:0] err_q, err_d;
   logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
   logic [DATA_W-1:0] ferr_data_q, ferr_data_d;
   logic              pass_q, pass_d;
`ifdef NIOS_RAM_TESTER_INV_PASS_EN
   logic              inv_q, inv_d;
`endif

   logic              push;
   logic              flush;
   logic              tail_valid;
   logic [ADDR_W-1:0] tail_addr;
   logic              inner_valid;
   logic [DATA_W-1:0] inv_mask;
   logic [DATA_W-1:0] pat_cur;
   logic [DATA_W-1:0] exp_data;
   logic              last_issue;
   logic              abort_hit;
   logic              cmp_en;

`ifdef NIOS_RAM_TESTER_INV_PASS_EN
   assign inv_mask = {DATA_W{inv_q}};
`else
   assign inv_mask = '0;
`endif

   assign pat_cur    = ram_pattern(seed_q, 16'(addr_q), ADDR_W) ^ inv_mask;
   assign exp_data   = ram_pattern(seed_q, 16'(tail_addr), ADDR_W) ^ inv_mask;
   assign busy       = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
   assign abort_hit  = abort & busy;
   assign last_issue = (remain_q == (ADDR_W+1)'(1));

   nios_ram_tester_rdpipe #(
      .ADDR_W (ADDR_W),
      .DEPTH  (READ_LATENCY)
   ) u_rdpipe (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .push        (push),
      .push_addr   (addr_q),
      .tail_valid  (tail_valid),
      .tail_addr   (tail_addr),
      .inner_valid (inner_valid)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      base_d      = base_q;
      count_d     = count_q;
      remain_d    = remain_q;
      seed_d      = seed_q;
      err_d       = err_q;
      ferr_addr_d = ferr_addr_q;
      ferr_data_d = ferr_data_q;
      pass_d      = pass_q;
`ifdef NIOS_RAM_TESTER_INV_PASS_EN
      inv_d       = inv_q;
`endif
      push        = 1'b0;
      flush       = abort_hit;
      // data already in flight when an abort lands is never judged
      cmp_en      = tail_valid & ~abort_hit;

      if (cmp_en && (m_readdata != exp_data)) begin
         err_d = err_q + 1'b1;
         if (err_q == '0) begin
            ferr_addr_d = tail_addr;
            ferr_data_d = m_readdata;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               seed_d      = seed;
               base_d      = base;
               count_d     = count;
               addr_d      = base;
               remain_d    = count;
               err_d       = '0;
               ferr_addr_d = '0;
               ferr_data_d = '0;
`ifdef NIOS_RAM_TESTER_INV_PASS_EN
               inv_d       = 1'b0;
`endif
               if (count == '0) begin
                  state_d = FIN;
                  pass_d  = 1'b1;
               end else begin
                  state_d = WRITE;
                  pass_d  = 1'b0;
               end
            end
         end
         WRITE: begin
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (last_issue) begin
               state_d  = READ;
               addr_d   = base_q;
               remain_d = count_q;
            end
         end
         READ: begin
            push     = 1'b1;
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (last_issue) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
`ifdef NIOS_RAM_TESTER_INV_PASS_EN
            if (!inv_q) begin
               if (!tail_valid && !inner_valid) begin
                  state_d  = WRITE;
                  inv_d    = 1'b1;
                  addr_d   = base_q;
                  remain_d = count_q;
               end
            end else if (!inner_valid) begin
               state_d = FIN;
               pass_d  = (err_d == '0);
            end
`else
            if (!inner_valid) begin
               state_d = FIN;
               pass_d  = (err_d == '0);
            end
`endif
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort_hit) begin
         state_d = FIN;
         pass_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         base_q      <= '0;
         count_q     <= '0;
         remain_q    <= '0;
         seed_q      <= '0;
         err_q       <= '0;
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
         pass_q      <= 1'b0;
`ifdef NIOS_RAM_TESTER_INV_PASS_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         count_q     <= count_d;
         remain_q    <= remain_d;
         seed_q      <= seed_d;
         err_q       <= err_d;
         ferr_addr_q <= ferr_addr_d;
         ferr_data_q <= ferr_data_d;
         pass_q      <= pass_d;
`ifdef NIOS_RAM_TESTER_INV_PASS_EN
         inv_q       <= inv_d;
`endif
      end
   end

   assign done           = (state_q == FIN);
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_addr_q;
   assign first_err_data = ferr_data_q;
   assign m_address      = addr_q;
   assign m_byteenable   = BE_ALL;
   assign m_chipselect   = (state_q == WRITE) || (state_q == READ);
   assign m_write        = (state_q == WRITE);
   assign m_writedata    = (state_q == WRITE) ? pat_cur : '0;
   assign m_clken        = 1'b1;

endmodule

// File: tb/tb_nios_ram_tester.sv
// Bench for nios_ram_tester: behavioural 1024x32 RAM with an optional stuck-at
// bit, a bus-order monitor, and per-test expectations computed from the rules.
module tb_nios_ram_tester;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] seed = '0;
   logic [9:0]  base = '0;
   logic [10:0] count = '0;
   logic        busy, done, pass;
   logic [11:0] err_count;
   logic [9:0]  first_err_addr;
   logic [31:0] first_err_data;
   logic [9:0]  m_address;
   logic [3:0]  m_byteenable;
   logic        m_chipselect, m_write, m_clken;
   logic [31:0] m_writedata, m_readdata;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   nios_ram_tester dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .abort          (abort),
      .seed           (seed),
      .base           (base),
      .count          (count),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data),
      .m_address      (m_address),
      .m_byteenable   (m_byteenable),
      .m_chipselect   (m_chipselect),
      .m_write        (m_write),
      .m_writedata    (m_writedata),
      .m_clken        (m_clken),
      .m_readdata     (m_readdata)
   );

   // pattern straight from its definition: seed, address in the top 10 bits, address in the low bits
   function automatic logic [31:0] pat(input logic [31:0] s, input int a);
      return s ^ (32'(a) * 32'h0040_0000) ^ 32'(a);
   endfunction

   // ---------------- RAM slave model ----------------
   logic [31:0] mem [1024];
   logic [9:0]  raddr = '0;
   logic        bus_cs = 1'b0, bus_we = 1'b0;
   logic [9:0]  bus_addr = '0;
   logic [31:0] bus_wd = '0;
   logic        fault_en = 1'b0;
   logic [9:0]  fault_addr = '0;
   int          fault_bit = 0;
   logic        fault_val = 1'b0;
   logic [31:0] fmask, rd_raw;

   assign fmask      = 32'd1 << fault_bit;
   assign rd_raw     = mem[raddr];
   assign m_readdata = (fault_en && raddr == fault_addr) ?
                       (fault_val ? (rd_raw | fmask) : (rd_raw & ~fmask)) : rd_raw;

   always @(posedge clk) begin
      if (bus_cs && bus_we) mem[bus_addr] <= bus_wd;
      raddr <= bus_addr;
   end

   // ---------------- bus monitor (captures mid-cycle) ----------------
   int          wr_cnt = 0, rd_cnt = 0, cs_cnt = 0, bus_bad = 0;
   int          wr0 = 0, rd0 = 0, cur_base = 0;
   logic [31:0] cur_seed = '0;

   always @(negedge clk) begin
      int bad;
      int exp_a;
      bad = 0;
      if (m_byteenable != 4'hF || m_clken != 1'b1) bad++;
      if (m_chipselect) begin
         if (m_write) begin
            exp_a = (cur_base + (wr_cnt - wr0)) % 1024;
            if (int'(m_address) != exp_a || m_writedata != pat(cur_seed, exp_a)) bad++;
            wr_cnt <= wr_cnt + 1;
         end else begin
            exp_a = (cur_base + (rd_cnt - rd0)) % 1024;
            if (int'(m_address) != exp_a) bad++;
            rd_cnt <= rd_cnt + 1;
         end
         cs_cnt <= cs_cnt + 1;
      end
      bus_bad  <= bus_bad + bad;
      bus_cs   <= m_chipselect;
      bus_we   <= m_write;
      bus_addr <= m_address;
      bus_wd   <= m_writedata;
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state(input string where);
      chk({where, "_busy"}, 32'(busy), 32'd0);
      chk({where, "_done"}, 32'(done), 32'd0);
      chk({where, "_pass"}, 32'(pass), 32'd0);
      chk({where, "_err_count"}, 32'(err_count), 32'd0);
      chk({where, "_first_err_addr"}, 32'(first_err_addr), 32'd0);
      chk({where, "_first_err_data"}, first_err_data, 32'd0);
      chk({where, "_chipselect"}, 32'(m_chipselect), 32'd0);
      chk({where, "_write"}, 32'(m_write), 32'd0);
      chk({where, "_address"}, 32'(m_address), 32'd0);
      chk({where, "_writedata"}, m_writedata, 32'd0);
      chk({where, "_byteenable"}, 32'(m_byteenable), 32'hF);
      chk({where, "_clken"}, 32'(m_clken), 32'd1);
   endtask

   task automatic kick(input logic [31:0] s, input int b, input int n);
      @(negedge clk);
      cur_seed = s;
      cur_base = b;
      wr0      = wr_cnt;
      rd0      = rd_cnt;
      seed     = s;
      base     = 10'(b);
      count    = 11'(n);
      start    = 1'b1;
   endtask

   task automatic run_test(input logic [31:0] s, input int b, input int n, input int abort_at);
      int          exp_err, exp_lat, exp_cs, lat, a, cs0, bad0;
      logic [31:0] p, exp_fa, exp_fd;
      logic        exp_pass;
      exp_err = 0;
      exp_fa  = '0;
      exp_fd  = '0;
      for (int i = 0; i < n; i++) begin
         a = (b + i) % 1024;
         p = pat(s, a);
         // read i is judged on the edge n+2+i cycles after start; abort on that edge discards it
         if (fault_en && a == int'(fault_addr) && p[fault_bit] != fault_val &&
             (abort_at == 0 || n + 2 + i < abort_at)) begin
            if (exp_err == 0) begin
               exp_fa = 32'(a);
               exp_fd = p ^ (32'd1 << fault_bit);
            end
            exp_err++;
         end
      end
      exp_pass = (abort_at == 0) && (exp_err == 0);
      if (n == 0)             exp_lat = 1;
      else if (abort_at != 0) exp_lat = abort_at + 1;
      else                    exp_lat = 2 * n + 2;
      exp_cs = (abort_at != 0 && abort_at < 2 * n) ? abort_at : 2 * n;
      cs0  = cs_cnt;
      bad0 = bus_bad;
      kick(s, b, n);
      lat = 0;
      for (int cyc = 1; cyc <= exp_lat + 50; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            start = 1'b0;
            chk("busy_after_start", 32'(busy), 32'(n != 0));
         end
         if (cyc == 4) start = 1'b0;
         if (cyc == abort_at + 1) abort = 1'b0;
         if (done) begin
            lat = cyc;
            break;
         end
         if (cyc == 3) begin
            start = 1'b1;
            seed  = ~s;
            base  = 10'(b + 7);
            count = 11'd3;
         end
         if (cyc == abort_at) abort = 1'b1;
      end
      start = 1'b0;
      abort = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("cs_at_done", 32'(m_chipselect), 32'd0);
      chk("pass", 32'(pass), 32'(exp_pass));
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("first_err_addr", 32'(first_err_addr), exp_fa);
      chk("first_err_data", first_err_data, exp_fd);
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("pass_held", 32'(pass), 32'(exp_pass));
      chk("bus_sequence", 32'(bus_bad - bad0), 32'd0);
      chk("cs_cycles", 32'(cs_cnt - cs0), 32'(exp_cs));
      $display("test seed=%h base=%0d count=%0d abort_at=%0d fault=%0b@%0d.%0d lat=%0d err=%0d pass=%0b",
               s, b, n, abort_at, fault_en, fault_addr, fault_bit, lat, err_count, pass);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] s;
      int          b, n, ab;

      repeat (3) @(negedge clk);
      check_reset_state("reset");
      reset_n = 1'b1;

      // full-range fault-free run
      run_test(32'hA5A5_0000, 0, 1024, 0);
      chk("mem_word5", mem[5], 32'hA5A5_0000 ^ 32'h0140_0005);

      // bit 3 of word 17 stuck at 1
      fault_en   = 1'b1;
      fault_addr = 10'd17;
      fault_bit  = 3;
      fault_val  = 1'b1;
      run_test(32'h0, 0, 32, 0);
      chk("stuck_first_addr", 32'(first_err_addr), 32'd17);
      chk("stuck_first_data", first_err_data, 32'h0440_0019);

      // async reset clears the latched failure at once
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_state("idle_reset");
      @(negedge clk);
      reset_n  = 1'b1;
      fault_en = 1'b0;

      run_test($urandom, 1020, 8, 0);
      run_test($urandom, 5, 0, 0);
      run_test($urandom, 0, 16, 19);

      // reset in the middle of the write phase
      kick(32'h1234_5678, 100, 64);
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("midwrite_cs_before_reset", 32'(m_chipselect & m_write), 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_state("midwrite_reset");
      @(negedge clk);
      reset_n = 1'b1;
      run_test(32'h1234_5678, 100, 64, 0);

      for (int t = 0; t < 12; t++) begin
         s  = $urandom;
         b  = int'($urandom_range(0, 1023));
         n  = (t == 0) ? 1 : int'($urandom_range(1, 40));
         fault_en   = 1'($urandom_range(0, 1));
         fault_addr = 10'((b + int'($urandom_range(0, n - 1))) % 1024);
         fault_bit  = int'($urandom_range(0, 31));
         fault_val  = 1'($urandom_range(0, 1));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * n + 1)) : 0;
         run_test(s, b, n, ab);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
